// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART word/byte constants and tx FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t c_ST_IDLE      = 3'd0;
    localparam tx_state_t c_ST_LOAD      = 3'd1;
    localparam tx_state_t c_ST_SEND      = 3'd2;
    localparam tx_state_t c_ST_WAIT_BUSY = 3'd3;
    localparam tx_state_t c_ST_WAIT_IDLE = 3'd4;

endpackage

`default_nettype wire

// File: rtl/uart_word_tx_if.sv
// ============================================================================
// Module      : uart_word_tx_if
// Description : Word input handshake plus byte-level uart transmitter link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_word_tx_if;
    import uart_pkg::*;

    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] tx_d;
    logic              tx_en;
    logic              tx_rdy;

    // master = core logic plus uart transmitter; slave = the serializer
    modport master (
        output in_word, in_valid, tx_rdy,
        input  in_ready, tx_d, tx_en
    );

    modport slave (
        input  in_word, in_valid, tx_rdy,
        output in_ready, tx_d, tx_en
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular FIFO with separate occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_count == c_FULL_CNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;

    // pointers are exactly log2(DEPTH) wide so they wrap without a compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_word_tx.sv
// ============================================================================
// Module      : uart_word_tx
// Description : Buffers 32-bit words and sends them LSB-byte first to a uart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CHECKSUM_EN = 0
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    uart_word_tx_if.slave                      bus,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

    localparam logic [2:0] c_LAST_IDX = 3'(BYTES_PER_WORD + CHECKSUM_EN);
    localparam logic [2:0] c_CSUM_IDX = 3'(BYTES_PER_WORD);

    tx_state_t          r_state;
    logic [WORD_W-1:0]  r_sh;
    logic [2:0]         r_byte_idx;
    logic [BYTE_W-1:0]  r_csum;
    logic [BYTE_W-1:0]  r_tx_d;
    logic               r_tx_en;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [WORD_W-1:0]  w_head;
    logic [BYTE_W-1:0]  w_byte;

    assign w_push = bus.in_valid & ~w_full;
    assign w_pop  = (r_state == c_ST_LOAD);
    assign w_byte = (r_byte_idx == c_CSUM_IDX) ? r_csum : r_sh[BYTE_W-1:0];

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (bus.in_word),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    assign bus.in_ready = ~w_full;
    assign bus.tx_d     = r_tx_d;
    assign bus.tx_en    = r_tx_en;
    assign busy         = (r_state != c_ST_IDLE) | ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_sh       <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_tx_d     <= '0;
            r_tx_en    <= 1'b0;
        end else begin
            r_tx_en <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) r_state <= c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    r_sh       <= w_head;
                    r_byte_idx <= '0;
                    r_csum     <= '0;
                    r_state    <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (bus.tx_rdy) begin
                        r_tx_d  <= w_byte;
                        r_tx_en <= 1'b1;
                        r_csum  <= r_csum ^ w_byte;
                        r_state <= c_ST_WAIT_BUSY;
                    end
                end
                // tx_rdy dropping is the uart's acknowledgement of the byte
                c_ST_WAIT_BUSY: begin
                    if (!bus.tx_rdy) begin
                        r_sh       <= r_sh >> BYTE_W;
                        r_byte_idx <= r_byte_idx + 3'd1;
                        r_state    <= c_ST_WAIT_IDLE;
                    end
                end
                c_ST_WAIT_IDLE: begin
                    if (bus.tx_rdy) begin
                        if (r_byte_idx < c_LAST_IDX) r_state <= c_ST_SEND;
                        else if (!w_empty)           r_state <= c_ST_LOAD;
                        else                         r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_word_tx.sv
// ============================================================================
// Module      : tb_uart_word_tx
// Description : Directed self-checking bench for uart_word_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_word_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0 = 1'b0;
    logic       rst_n1 = 1'b0;
    logic       busy0, busy1;
    logic [2:0] cnt0, cnt1;

    uart_word_tx_if if0();
    uart_word_tx_if if1();

    uart_word_tx #(.FIFO_DEPTH(4), .CHECKSUM_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(if0.slave), .busy(busy0), .fifo_count(cnt0)
    );

    uart_word_tx #(.FIFO_DEPTH(4), .CHECKSUM_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(if1.slave), .busy(busy1), .fifo_count(cnt1)
    );

    // uart model: after each tx_en it reports not-ready for 3 cycles
    logic       rdy_en0 = 1'b0;
    logic       rdy_en1 = 1'b1;
    int         bcnt0 = 0;
    int         bcnt1 = 0;
    int         dbl0 = 0;
    int         dbl1 = 0;
    logic       prev_en0 = 1'b0;
    logic       prev_en1 = 1'b0;
    logic [7:0] cap0[$];
    logic [7:0] cap1[$];

    assign if0.tx_rdy = rdy_en0 && (bcnt0 == 0);
    assign if1.tx_rdy = rdy_en1 && (bcnt1 == 0);

    always @(posedge clk) begin
        if (if0.tx_en) bcnt0 <= 3; else if (bcnt0 > 0) bcnt0 <= bcnt0 - 1;
        if (if1.tx_en) bcnt1 <= 3; else if (bcnt1 > 0) bcnt1 <= bcnt1 - 1;
        if (if0.tx_en) cap0.push_back(if0.tx_d);
        if (if1.tx_en) cap1.push_back(if1.tx_d);
        if (if0.tx_en && prev_en0) dbl0 <= dbl0 + 1;
        if (if1.tx_en && prev_en1) dbl1 <= dbl1 + 1;
        prev_en0 <= if0.tx_en;
        prev_en1 <= if1.tx_en;
    end

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] word_of(input int i);
        return 32'h10213243 + 32'(i) * 32'h04040404;
    endfunction

    task automatic push0(input logic [31:0] w);
        int t;
        t = 0;
        @(negedge clk);
        if0.in_word  = w;
        if0.in_valid = 1'b1;
        while (!if0.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!if0.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL push0_timeout: in_ready got 0, required 1 within 300 cycles");
        end
        @(negedge clk);
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_bytes0(input int n, input int budget);
        int t;
        t = 0;
        while (cap0.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (cap0.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL wait_bytes0: got %0d bytes, required %0d", cap0.size(), n);
        end
    endtask

    task automatic wait_idle0(input int budget);
        int t;
        t = 0;
        while (busy0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL idle0: busy got %b, required 0", busy0);
        end
    endtask

    task automatic test_reset;
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        if0.in_word  = '0;
        if1.in_word  = '0;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (if0.tx_en !== 1'b0)    begin n_err++; $display("FAIL reset_tx_en: got %b, required 0", if0.tx_en); end
        n_cmp++; if (if0.tx_d !== 8'h00)    begin n_err++; $display("FAIL reset_tx_d: got %h, required 00", if0.tx_d); end
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", if0.in_ready); end
        n_cmp++; if (busy0 !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy0); end
        n_cmp++; if (cnt0 !== 3'd0)         begin n_err++; $display("FAIL reset_count: got %0d, required 0", cnt0); end
        n_cmp++; if (busy1 !== 1'b0)        begin n_err++; $display("FAIL reset_busy1: got %b, required 0", busy1); end
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        int base;
        logic [7:0] got;
        logic [31:0] w;
        rdy_en0 = 1'b1;
        base = cap0.size();
        w = 32'h44332211;
        push0(w);
        n_cmp++; if (cnt0 !== 3'd1) begin n_err++; $display("FAIL single_cnt_push: got %0d, required 1", cnt0); end
        @(negedge clk);
        n_cmp++; if (if0.tx_en !== 1'b0) begin n_err++; $display("FAIL single_lat_e1: tx_en got %b, required 0", if0.tx_en); end
        n_cmp++; if (cnt0 !== 3'd1) begin n_err++; $display("FAIL single_cnt_load: got %0d, required 1", cnt0); end
        @(negedge clk);
        n_cmp++; if (if0.tx_en !== 1'b0) begin n_err++; $display("FAIL single_lat_e2: tx_en got %b, required 0", if0.tx_en); end
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL single_cnt_pop: got %0d, required 0", cnt0); end
        @(negedge clk);
        n_cmp++; if (if0.tx_en !== 1'b1) begin n_err++; $display("FAIL single_lat_e3: tx_en got %b, required 1", if0.tx_en); end
        n_cmp++; if (if0.tx_d !== 8'h11) begin n_err++; $display("FAIL single_first_d: got %h, required 11", if0.tx_d); end
        wait_bytes0(base + 4, 200);
        wait_idle0(200);
        repeat (10) @(negedge clk);
        n_cmp++; if (cap0.size() !== base + 4) begin n_err++; $display("FAIL single_nbytes: got %0d, required %0d", cap0.size() - base, 4); end
        for (int j = 0; j < 4; j++) begin
            got = (base + j < cap0.size()) ? cap0[base + j] : 8'hxx;
            n_cmp++;
            if (got !== w[8*j +: 8]) begin n_err++; $display("FAIL single_byte%0d: got %h, required %h", j, got, w[8*j +: 8]); end
        end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b, required 0", busy0); end
    endtask

    task automatic test_checksum;
        int base;
        int t;
        logic [7:0] got;
        logic [7:0] exp [5];
        exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        base = cap1.size();
        @(negedge clk);
        if1.in_word  = 32'hDEADBEEF;
        if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        t = 0;
        while ((cap1.size() < base + 5 || busy1) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (cap1.size() !== base + 5) begin n_err++; $display("FAIL csum_nbytes: got %0d, required 5", cap1.size() - base); end
        for (int j = 0; j < 5; j++) begin
            got = (base + j < cap1.size()) ? cap1[base + j] : 8'hxx;
            n_cmp++;
            if (got !== exp[j]) begin n_err++; $display("FAIL csum_byte%0d: got %h, required %h", j, got, exp[j]); end
        end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL csum_busy_end: got %b, required 0", busy1); end
    endtask

    // one word is popped into the shift register before the stall, so
    // five are taken in total and four remain buffered
    task automatic test_fifo_full;
        int base;
        int acc;
        logic take;
        logic [7:0] got;
        logic [31:0] w;
        rdy_en0 = 1'b0;
        base = cap0.size();
        acc = 0;
        @(negedge clk);
        repeat (12) begin
            take = 1'b0;
            if (acc < 6) begin
                if0.in_word  = word_of(acc);
                if0.in_valid = 1'b1;
                take = if0.in_ready;
            end else begin
                if0.in_valid = 1'b0;
            end
            @(negedge clk);
            if (take) acc++;
        end
        if0.in_valid = 1'b0;
        n_cmp++; if (acc !== 5)              begin n_err++; $display("FAIL full_accepted: got %0d, required 5", acc); end
        n_cmp++; if (cnt0 !== 3'd4)          begin n_err++; $display("FAIL full_count: got %0d, required 4", cnt0); end
        n_cmp++; if (if0.in_ready !== 1'b0)  begin n_err++; $display("FAIL full_in_ready: got %b, required 0", if0.in_ready); end
        n_cmp++; if (cap0.size() !== base)   begin n_err++; $display("FAIL full_no_tx: got %0d bytes, required 0", cap0.size() - base); end
        rdy_en0 = 1'b1;
        wait_bytes0(base + 20, 800);
        wait_idle0(200);
        repeat (10) @(negedge clk);
        n_cmp++; if (cap0.size() !== base + 20) begin n_err++; $display("FAIL full_nbytes: got %0d, required 20", cap0.size() - base); end
        for (int i = 0; i < 5; i++) begin
            w = word_of(i);
            for (int j = 0; j < 4; j++) begin
                got = (base + 4*i + j < cap0.size()) ? cap0[base + 4*i + j] : 8'hxx;
                n_cmp++;
                if (got !== w[8*j +: 8]) begin n_err++; $display("FAIL full_w%0d_b%0d: got %h, required %h", i, j, got, w[8*j +: 8]); end
            end
        end
    endtask

    task automatic test_wrap;
        int base;
        logic [7:0] got;
        logic [31:0] w;
        base = cap0.size();
        fork
            begin
                for (int i = 0; i < 10; i++) push0(word_of(10 + i));
            end
            begin
                repeat (150) begin
                    @(negedge clk);
                    rdy_en0 = ($urandom_range(0, 2) != 0);
                end
                rdy_en0 = 1'b1;
            end
        join
        rdy_en0 = 1'b1;
        wait_bytes0(base + 40, 3000);
        wait_idle0(300);
        repeat (10) @(negedge clk);
        n_cmp++; if (cap0.size() !== base + 40) begin n_err++; $display("FAIL wrap_nbytes: got %0d, required 40", cap0.size() - base); end
        for (int i = 0; i < 10; i++) begin
            w = word_of(10 + i);
            for (int j = 0; j < 4; j++) begin
                got = (base + 4*i + j < cap0.size()) ? cap0[base + 4*i + j] : 8'hxx;
                n_cmp++;
                if (got !== w[8*j +: 8]) begin n_err++; $display("FAIL wrap_w%0d_b%0d: got %h, required %h", i, j, got, w[8*j +: 8]); end
            end
        end
    endtask

    task automatic test_push_pop;
        int base;
        logic [7:0] got;
        logic [31:0] w [2];
        logic [31:0] cw;
        w = '{32'hCAFEF00D, 32'h0BADC0DE};
        rdy_en0 = 1'b1;
        base = cap0.size();
        push0(w[0]);
        @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd1) begin n_err++; $display("FAIL pp_cnt_before: got %0d, required 1", cnt0); end
        if0.in_word  = w[1];
        if0.in_valid = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0;
        n_cmp++; if (cnt0 !== 3'd1) begin n_err++; $display("FAIL pp_cnt_after: got %0d, required 1", cnt0); end
        wait_bytes0(base + 8, 400);
        wait_idle0(200);
        repeat (10) @(negedge clk);
        n_cmp++; if (cap0.size() !== base + 8) begin n_err++; $display("FAIL pp_nbytes: got %0d, required 8", cap0.size() - base); end
        for (int i = 0; i < 2; i++) begin
            cw = w[i];
            for (int j = 0; j < 4; j++) begin
                got = (base + 4*i + j < cap0.size()) ? cap0[base + 4*i + j] : 8'hxx;
                n_cmp++;
                if (got !== cw[8*j +: 8]) begin n_err++; $display("FAIL pp_w%0d_b%0d: got %h, required %h", i, j, got, cw[8*j +: 8]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        rdy_en0 = 1'b1;
        base = cap0.size();
        push0(32'h11111111);
        push0(32'h22222222);
        push0(32'h33333333);
        wait_bytes0(base + 2, 300);
        n_cmp++; if (cnt0 !== 3'd2) begin n_err++; $display("FAIL rmid_queued: got %0d, required 2", cnt0); end
        rst_n0 = 1'b0;
        @(negedge clk);
        rst_n0 = 1'b1;
        n_cmp++; if (if0.tx_en !== 1'b0)    begin n_err++; $display("FAIL rmid_tx_en: got %b, required 0", if0.tx_en); end
        n_cmp++; if (cnt0 !== 3'd0)         begin n_err++; $display("FAIL rmid_count: got %0d, required 0", cnt0); end
        n_cmp++; if (busy0 !== 1'b0)        begin n_err++; $display("FAIL rmid_busy: got %b, required 0", busy0); end
        n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b, required 1", if0.in_ready); end
        repeat (60) @(negedge clk);
        n_cmp++; if (cap0.size() !== base + 2) begin n_err++; $display("FAIL rmid_no_more: got %0d bytes, required 2", cap0.size() - base); end
    endtask

    task automatic test_stall;
        int base;
        logic [7:0] got;
        logic [31:0] w;
        w = 32'h89ABCDEF;
        rdy_en0 = 1'b0;
        base = cap0.size();
        push0(w);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (if0.tx_en !== 1'b0) begin n_err++; $display("FAIL stall_c%0d: tx_en got %b, required 0", c, if0.tx_en); end
        end
        rdy_en0 = 1'b1;
        @(negedge clk);
        n_cmp++; if (if0.tx_en !== 1'b1) begin n_err++; $display("FAIL stall_release: tx_en got %b, required 1", if0.tx_en); end
        n_cmp++; if (if0.tx_d !== 8'hEF) begin n_err++; $display("FAIL stall_first_d: got %h, required ef", if0.tx_d); end
        wait_bytes0(base + 4, 200);
        wait_idle0(200);
        repeat (10) @(negedge clk);
        n_cmp++; if (cap0.size() !== base + 4) begin n_err++; $display("FAIL stall_nbytes: got %0d, required 4", cap0.size() - base); end
        for (int j = 0; j < 4; j++) begin
            got = (base + j < cap0.size()) ? cap0[base + j] : 8'hxx;
            n_cmp++;
            if (got !== w[8*j +: 8]) begin n_err++; $display("FAIL stall_byte%0d: got %h, required %h", j, got, w[8*j +: 8]); end
        end
    endtask

    task automatic test_protocol;
        n_cmp++; if (dbl0 !== 0) begin n_err++; $display("FAIL proto_double_en0: got %0d, required 0", dbl0); end
        n_cmp++; if (dbl1 !== 0) begin n_err++; $display("FAIL proto_double_en1: got %0d, required 0", dbl1); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_checksum();
        test_fifo_full();
        test_wrap();
        test_push_pop();
        test_reset_mid();
        test_stall();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
